// File: rtl/microsequencer.sv
// microsequencer: next-state generator for the microprogrammed control unit.
// Selects the next control state from the microstore's select field, the
// condition tester, the opcode encoder, a one-deep call/return register and
// a memory-wait watchdog. All outputs come straight from flops.
module microsequencer #(
  parameter int STATE_W       = 7,
  parameter int FETCH_STATE   = 1,
  parameter int ILLEGAL_STATE = 5,
  parameter int TIMEOUT       = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         ns_sel,
  input  logic [STATE_W-1:0] cr_addr,
  input  logic               cond,
  input  logic               inv,
  input  logic               moc,
  input  logic [5:0]         opcode,
  output logic [STATE_W-1:0] current_state,
  output logic               ret_valid,
  output logic               moc_timeout
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [STATE_W-1:0] ST_FETCH   = STATE_W'(FETCH_STATE);
  localparam logic [STATE_W-1:0] ST_ILLEGAL = STATE_W'(ILLEGAL_STATE);
  localparam logic [CNT_W-1:0]   CNT_LIMIT  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    NS_INC    = 3'b000,
    NS_DECODE = 3'b001,
    NS_JUMP   = 3'b010,
    NS_BRANCH = 3'b011,
    NS_WAIT   = 3'b100,
    NS_CALL   = 3'b101,
    NS_RET    = 3'b110,
    NS_FETCH  = 3'b111
  } ns_sel_e;

  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] ret_q, ret_d;
  logic               ret_valid_q, ret_valid_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               timeout_q, timeout_d;

  logic [STATE_W-1:0] inc;
  logic [STATE_W-1:0] enc_state;
  logic               cond_eff;

  assign inc      = state_q + STATE_W'(1);
  assign cond_eff = cond ^ inv;

  // Opcode encoder: maps IR[31:26] to the first microstate of each instruction.
  always_comb begin
    case (opcode)
      6'b000000: enc_state = STATE_W'(6);
      6'b100011: enc_state = STATE_W'(7);
      6'b101011: enc_state = STATE_W'(13);
      6'b000100: enc_state = STATE_W'(16);
      6'b001000: enc_state = STATE_W'(17);
      6'b000010: enc_state = STATE_W'(18);
      6'b001111: enc_state = STATE_W'(19);
      default:   enc_state = ST_ILLEGAL;
    endcase
  end

  // Next-state select, call/return bookkeeping and the MOC wait watchdog.
  always_comb begin
    state_d     = inc;
    ret_d       = ret_q;
    ret_valid_d = ret_valid_q;
    wait_cnt_d  = '0;
    timeout_d   = timeout_q;
    case (ns_sel_e'(ns_sel))
      NS_INC:    state_d = inc;
      NS_DECODE: state_d = enc_state;
      NS_JUMP:   state_d = cr_addr;
      NS_BRANCH: state_d = cond_eff ? cr_addr : inc;
      NS_WAIT: begin
        // moc high wins even on the edge that would otherwise time out
        if (moc) begin
          state_d = inc;
        end else if (wait_cnt_q == CNT_LIMIT) begin
          state_d   = ST_ILLEGAL;
          timeout_d = 1'b1;
        end else begin
          state_d    = state_q;
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      NS_CALL: begin
        // single level: a nested call simply overwrites the saved return
        ret_d       = inc;
        ret_valid_d = 1'b1;
        state_d     = cr_addr;
      end
      NS_RET: begin
        if (ret_valid_q) begin
          state_d     = ret_q;
          ret_valid_d = 1'b0;
        end else begin
          state_d = ST_ILLEGAL;
        end
      end
      NS_FETCH:  state_d = ST_FETCH;
      default:   state_d = inc;
    endcase
  end

  // Sequencer registers; synchronous reset discards all wait/call context.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= '0;
      ret_q       <= '0;
      ret_valid_q <= 1'b0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      ret_valid_q <= ret_valid_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign current_state = state_q;
  assign ret_valid     = ret_valid_q;
  assign moc_timeout   = timeout_q;

endmodule

// File: doc/microsequencer.md
# microsequencer

Next-state generator for the microprogrammed control unit. Each cycle it takes the next-state select fields that the microstore emits for the current state, plus condition, memory-handshake and opcode inputs. From these it registers the next 7-bit control state, which feeds back to the microstore. It also contains the opcode encoder, a single-level call/return register and a memory-operation-complete (MOC) wait watchdog.

## Interface
Parameters:
- STATE_W, 7, state/address width
- FETCH_STATE, 1, target of ns_sel=111
- ILLEGAL_STATE, 5, target of unknown opcode, bad return, MOC timeout
- TIMEOUT, 15, max consecutive wait edges with moc low

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- ns_sel  in  3  next-state select from microstore
- cr_addr  in  STATE_W  branch/jump/call target from microstore
- cond  in  1  condition-tester result
- inv  in  1  invert cond before test
- moc  in  1  memory operation complete
- opcode  in  6  IR[31:26] for encoder
- current_state  out  STATE_W  registered control state
- ret_valid  out  1  return register holds an address
- moc_timeout  out  1  sticky watchdog flag

## Operation
- ns_sel decode (c = cond ^ inv, inc = current_state+1 mod 2^STATE_W):
  - 000: inc
  - 001: encoder(opcode)
  - 010: cr_addr
  - 011: c ? cr_addr : inc
  - 100: wait. moc=1 → inc; moc=0 → hold current_state; watchdog applies.
  - 101: call. ret_reg←inc, ret_valid←1, next=cr_addr. A call with ret_valid=1 overwrites ret_reg (single level).
  - 110: return. ret_valid=1 → ret_reg, ret_valid←0; ret_valid=0 → ILLEGAL_STATE.
  - 111: FETCH_STATE
- Encoder map:
  - 000000 → 6
  - 100011 → 7
  - 101011 → 13
  - 000100 → 16
  - 001000 → 17
  - 000010 → 18
  - 001111 → 19
  - any other opcode → ILLEGAL_STATE
- Watchdog: wait_cnt, width $clog2(TIMEOUT+1).
  - Edge with ns_sel=100 and moc=0:
    - wait_cnt==TIMEOUT-1 → next=ILLEGAL_STATE, moc_timeout←1, wait_cnt←0
    - otherwise → wait_cnt+1
  - Any other edge → wait_cnt←0.
  - moc=1 on the limit edge takes priority: next=inc, no timeout.
- moc_timeout stays set until reset. Other ns_sel codes are unaffected by it.
- Increment wraps 127→0. No saturation.
- Reset has priority over every input at the edge:
  - current_state←0, ret_reg←0, ret_valid←0, wait_cnt←0, moc_timeout←0.
  - Reset asserted mid-wait or mid-call discards all context.

## Timing
- Next state is combinational from current inputs and is registered on the rising clk edge. Latency is 1 cycle, one transition per cycle.
- All outputs are registered; no combinational input→output path. The microstore loop current_state→ns_sel→next is the single-cycle critical path.
- Reset values: current_state=0, ret_valid=0, moc_timeout=0.
- moc is sampled only on edges where ns_sel=100. It is level-sensitive; no pulse capture.
- ret_valid and moc_timeout update on the same edge as the transition that changes them.

## Test plan
- Reset and increment:
  - Stimulus: reset high for 2 edges; release with ns_sel=000 for 3 edges.
  - Response: state 0, both flags 0 during reset; then state 1,2,3.
- Encoder:
  - Stimulus: ns_sel=001 with opcode 100011, then 101011, then 111111.
  - Response: state 7, then 13, then 5.
- Branch:
  - Stimulus: in state 3, ns_sel=011, cr_addr=12, cond=1, inv=0. Repeat from state 3 with inv=1.
  - Response: first case → 12; second case → 4.
- Wait and watchdog:
  - Stimulus A: in state 9, ns_sel=100, moc low for 3 edges, then high.
  - Response A: state 9 for 3 edges, then 10, moc_timeout=0.
  - Stimulus B: moc held low throughout.
  - Response B: state 9 for 14 edges; 15th edge → 5 with moc_timeout=1; flag remains 1 until reset.
- Call/return:
  - Stimulus: in state 2, ns_sel=101, cr_addr=14; then ns_sel=110; then ns_sel=110 again.
  - Response: 14 with ret_valid=1; then 3 with ret_valid=0; then 5.
- Wrap and reset mid-wait:
  - Stimulus: reach state 127 via ns_sel=010, cr_addr=127, then ns_sel=000. Separately, assert reset on the 5th edge of a wait.
  - Response: 127→0. Reset case gives state 0; the next wait needs a full 15 edges to time out.
